// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared encodings for the fetch sequencer: EX redirect opcodes and FSM states.
// Imported by pc_fetch_sequencer and pc_target_calc.
package pc_fetch_sequencer_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } pcseq_state_e;

  // Any encoding outside the three redirect ops behaves as sequential fetch.
  function automatic logic is_redirect_op(input logic [2:0] op);
    return (op == NPC_BRANCH) || (op == NPC_JUMP) || (op == NPC_JALR);
  endfunction

endpackage

// File: rtl/pc_fetch_sequencer_target_calc.sv
// Combinational next-PC arithmetic: redirect target mux and sequential PC+4.
// No state; all adds wrap modulo 2^32.
module pc_target_calc
  import pc_fetch_sequencer_pkg::*;
(
  input  logic [2:0]  npc_op,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_aluout,
  input  logic [31:0] pc,
  output logic        redirect_op,
  output logic [31:0] target,
  output logic [31:0] seq_pc
);

  assign redirect_op = is_redirect_op(npc_op);
  assign seq_pc      = pc + 32'd4;

  always_comb begin
    target = ex_pc + ex_imm;
    if (npc_op == NPC_JALR)
      target = ex_aluout & ~32'h1;
  end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Architectural PC owner: merges EX redirects, load-use stall and a single-outstanding
// imem handshake. Optional perf counters built when PCSEQ_PERF_CNT_EN is defined.
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [2:0]       npc_op,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_aluout,
  input  logic             hazard_stall,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc,
  output logic             if_valid,
  output logic             flush,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] discard_cnt
);

  pcseq_state_e state;
  logic [31:0]  pc_q;
  logic [31:0]  pend_tgt;
  logic         imem_req_q;
  logic         redirect_op;
  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  seq_pc;

  pc_target_calc u_target_calc (
    .npc_op      (npc_op),
    .ex_pc       (ex_pc),
    .ex_imm      (ex_imm),
    .ex_aluout   (ex_aluout),
    .pc          (pc_q),
    .redirect_op (redirect_op),
    .target      (target),
    .seq_pc      (seq_pc)
  );

  // Redirects are ignored in BOOT: EX holds nothing meaningful yet.
  assign redirect  = redirect_op && (state != BOOT);
  assign flush     = redirect;
  assign if_valid  = (state == FETCH) && imem_ready && !hazard_stall && !redirect;
  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= BOOT;
      pc_q       <= RESET_PC;
      pend_tgt   <= 32'h0;
      imem_req_q <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state      <= FETCH;
          imem_req_q <= 1'b1;
        end
        FETCH: begin
          if (redirect) begin
            if (imem_ready) begin
              pc_q <= target;
            end else begin
              // The outstanding request must complete before the address may move.
              pend_tgt <= target;
              state    <= DISCARD;
            end
          end else if (imem_ready && !hazard_stall) begin
            pc_q <= seq_pc;
          end
        end
        DISCARD: begin
          if (redirect)
            pend_tgt <= target;
          if (imem_ready) begin
            pc_q  <= redirect ? target : pend_tgt;
            state <= FETCH;
          end
        end
        default: begin
          state      <= BOOT;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef PCSEQ_PERF_CNT_EN
  logic             discard_evt;
  logic [CNT_W-1:0] redirect_cnt_q;
  logic [CNT_W-1:0] discard_cnt_q;

  // A response is wasted if it lands in DISCARD, or in FETCH while it cannot be used.
  assign discard_evt = imem_ready &&
                       ((state == DISCARD) ||
                        ((state == FETCH) && (redirect || hazard_stall)));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      redirect_cnt_q <= '0;
      discard_cnt_q  <= '0;
    end else begin
      if (redirect)
        redirect_cnt_q <= redirect_cnt_q + 1'b1;
      if (discard_evt)
        discard_cnt_q <= discard_cnt_q + 1'b1;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign discard_cnt  = discard_cnt_q;
`else
  assign redirect_cnt = '0;
  assign discard_cnt  = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed self-checking bench for pc_fetch_sequencer (default build, counters tied off).
module tb_pc_fetch_sequencer;
  import pc_fetch_sequencer_pkg::*;

  logic        clk;
  logic        rstn;
  logic [2:0]  npc_op;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_aluout;
  logic        hazard_stall;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic        if_valid;
  logic        flush;
  logic [31:0] redirect_cnt;
  logic [31:0] discard_cnt;

  int checks;
  int passed;

  pc_fetch_sequencer #(.RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .npc_op       (npc_op),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .ex_aluout    (ex_aluout),
    .hazard_stall (hazard_stall),
    .imem_ready   (imem_ready),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .pc           (pc),
    .if_valid     (if_valid),
    .flush        (flush),
    .redirect_cnt (redirect_cnt),
    .discard_cnt  (discard_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Moves the PC to addr via a JUMP taken while FETCH has ready=1.
  task automatic jump_to(input logic [31:0] addr);
    npc_op       = NPC_JUMP;
    ex_pc        = 32'h0;
    ex_imm       = addr;
    imem_ready   = 1'b1;
    hazard_stall = 1'b0;
    tick();
    npc_op = NPC_PLUS4;
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; npc_op = NPC_PLUS4; ex_pc = 0; ex_imm = 0; ex_aluout = 0;
    hazard_stall = 1'b0; imem_ready = 1'b1;
    tick(); tick();
    checks++;
    if (pc !== 32'h0 || imem_req !== 1'b0 || if_valid !== 1'b0 || flush !== 1'b0)
      $display("FAIL reset_state: pc=%h req=%b vld=%b flush=%b, expected pc=0 req=0 vld=0 flush=0",
               pc, imem_req, if_valid, flush);
    else passed++;
    rstn = 1'b1;
    #1;
    // BOOT: a redirect op must be ignored
    npc_op = NPC_JUMP; ex_imm = 32'h500;
    #1;
    checks++;
    if (flush !== 1'b0 || if_valid !== 1'b0 || imem_req !== 1'b0)
      $display("FAIL boot_cycle: flush=%b vld=%b req=%b, expected 0 0 0", flush, if_valid, imem_req);
    else passed++;
    tick();
    npc_op = NPC_PLUS4;
    #1;
    checks++;
    if (pc !== 32'h0 || imem_req !== 1'b1)
      $display("FAIL boot_exit: pc=%h req=%b, expected pc=0 req=1", pc, imem_req);
    else passed++;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (pc !== 32'(i * 4) || imem_addr !== 32'(i * 4) || if_valid !== 1'b1)
        $display("FAIL seq_%0d: pc=%h addr=%h vld=%b, expected pc=addr=%h vld=1",
                 i, pc, imem_addr, if_valid, 32'(i * 4));
      else passed++;
      tick();
    end
  endtask

  task automatic test_branch();
    jump_to(32'h40);
    npc_op = NPC_BRANCH; ex_pc = 32'h38; ex_imm = 32'h10; imem_ready = 1'b1;
    #1;
    checks++;
    if (pc !== 32'h40 || flush !== 1'b1 || if_valid !== 1'b0)
      $display("FAIL branch_cycle: pc=%h flush=%b vld=%b, expected pc=40 flush=1 vld=0",
               pc, flush, if_valid);
    else passed++;
    tick();
    npc_op = NPC_PLUS4;
    #1;
    checks++;
    if (pc !== 32'h48 || flush !== 1'b0 || if_valid !== 1'b1)
      $display("FAIL branch_target: pc=%h flush=%b vld=%b, expected pc=48 flush=0 vld=1",
               pc, flush, if_valid);
    else passed++;
  endtask

  task automatic test_unknown_op();
    npc_op = 3'b111; imem_ready = 1'b1;
    #1;
    checks++;
    if (flush !== 1'b0 || if_valid !== 1'b1)
      $display("FAIL unknown_op: flush=%b vld=%b, expected flush=0 vld=1", flush, if_valid);
    else passed++;
    tick();
    npc_op = NPC_PLUS4;
    #1;
    checks++;
    if (pc !== 32'h4C)
      $display("FAIL unknown_op_pc: pc=%h, expected 4c", pc);
    else passed++;
  endtask

  task automatic test_discard();
    int flushes;
    jump_to(32'h20);
    imem_ready = 1'b0; npc_op = NPC_JALR; ex_aluout = 32'h101;
    #1;
    flushes = int'(flush);
    checks++;
    if (flush !== 1'b1 || if_valid !== 1'b0)
      $display("FAIL jalr_cycle: flush=%b vld=%b, expected flush=1 vld=0", flush, if_valid);
    else passed++;
    tick();
    npc_op = NPC_PLUS4;
    for (int k = 1; k <= 3; k++) begin
      imem_ready = (k == 3);
      #1;
      flushes += int'(flush);
      checks++;
      if (pc !== 32'h20 || imem_addr !== 32'h20 || imem_req !== 1'b1 || if_valid !== 1'b0)
        $display("FAIL discard_wait_%0d: pc=%h addr=%h req=%b vld=%b, expected pc=addr=20 req=1 vld=0",
                 k, pc, imem_addr, imem_req, if_valid);
      else passed++;
      tick();
    end
    #1;
    flushes += int'(flush);
    checks++;
    if (pc !== 32'h100 || if_valid !== 1'b1 || flushes != 1)
      $display("FAIL discard_exit: pc=%h vld=%b flushes=%0d, expected pc=100 vld=1 flushes=1",
               pc, if_valid, flushes);
    else passed++;
  endtask

  task automatic test_stall();
    jump_to(32'h10);
    hazard_stall = 1'b1; imem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (if_valid !== 1'b0 || flush !== 1'b0)
        $display("FAIL stall_vld_%0d: vld=%b flush=%b, expected 0 0", k, if_valid, flush);
      else passed++;
      tick();
      checks++;
      if (pc !== 32'h10)
        $display("FAIL stall_pc_%0d: pc=%h, expected 10", k, pc);
      else passed++;
    end
    hazard_stall = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b1)
      $display("FAIL stall_release: vld=%b, expected 1", if_valid);
    else passed++;
    tick();
    checks++;
    if (pc !== 32'h14)
      $display("FAIL stall_release_pc: pc=%h, expected 14", pc);
    else passed++;
    hazard_stall = 1'b1; npc_op = NPC_JUMP; ex_pc = 32'h14; ex_imm = 32'h100;
    #1;
    checks++;
    if (flush !== 1'b1 || if_valid !== 1'b0)
      $display("FAIL stall_jump: flush=%b vld=%b, expected flush=1 vld=0", flush, if_valid);
    else passed++;
    tick();
    npc_op = NPC_PLUS4; hazard_stall = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h114)
      $display("FAIL stall_jump_pc: pc=%h, expected 114", pc);
    else passed++;
  endtask

  task automatic test_wrap();
    npc_op = NPC_JUMP; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'hC; imem_ready = 1'b1;
    tick();
    npc_op = NPC_PLUS4;
    #1;
    checks++;
    if (pc !== 32'hFFFF_FFFC || if_valid !== 1'b1)
      $display("FAIL wrap_pre: pc=%h vld=%b, expected fffffffc 1", pc, if_valid);
    else passed++;
    tick();
    checks++;
    if (pc !== 32'h0)
      $display("FAIL wrap_pc: pc=%h, expected 0", pc);
    else passed++;
  endtask

  task automatic test_reset_mid_discard();
    imem_ready = 1'b0; npc_op = NPC_JALR; ex_aluout = 32'h200;
    tick();
    npc_op = NPC_PLUS4;
    #1;
    rstn = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0 || imem_req !== 1'b0 || if_valid !== 1'b0)
      $display("FAIL reset_discard: pc=%h req=%b vld=%b, expected pc=0 req=0 vld=0",
               pc, imem_req, if_valid);
    else passed++;
    imem_ready = 1'b1;
    tick();
    rstn = 1'b1;
    tick();
    checks++;
    if (pc !== 32'h0 || imem_req !== 1'b1 || if_valid !== 1'b1)
      $display("FAIL reset_recover: pc=%h req=%b vld=%b, expected pc=0 req=1 vld=1",
               pc, imem_req, if_valid);
    else passed++;
    tick();
    checks++;
    if (pc !== 32'h4)
      $display("FAIL reset_recover_pc: pc=%h, expected 4", pc);
    else passed++;
  endtask

  task automatic test_counters_tied();
    checks++;
    if (redirect_cnt !== 32'h0 || discard_cnt !== 32'h0)
      $display("FAIL counters_tied: redirect_cnt=%0d discard_cnt=%0d, expected 0 0",
               redirect_cnt, discard_cnt);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_unknown_op();
    test_discard();
    test_stall();
    test_wrap();
    test_reset_mid_discard();
`ifndef PCSEQ_PERF_CNT_EN
    test_counters_tied();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
